// File: rtl/mem_ss_csr_dfh_bridge.sv
// EMIF DFH feature CSRs (DFH, STATUS, CAPABILITY, SCRATCH) on an AXI4-Lite
// slave. The 0x800-0xFFF window is forwarded as 32-bit AVMM accesses.
// Ports: s_aw*/s_w*/s_b*/s_ar*/s_r* AXI-Lite slave (12-bit addr, 64-bit data),
//   cal_success/cal_fail async calibration levels, memss_* AVMM master.
module mem_ss_csr_dfh_bridge #(
   parameter int unsigned NUM_CH          = 4,
   parameter logic [3:0]  FEAT_VER        = 4'h1,
   parameter logic [23:0] NEXT_DFH_OFFSET = 24'h1000,
   parameter logic        END_OF_LIST     = 1'b0,
   parameter int unsigned TIMEOUT_CYC     = 256,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [11:0]       s_awaddr,
   input  logic              s_wvalid,
   output logic              s_wready,
   input  logic [63:0]       s_wdata,
   input  logic [7:0]        s_wstrb,
   output logic              s_bvalid,
   input  logic              s_bready,
   output logic [1:0]        s_bresp,
   input  logic              s_arvalid,
   output logic              s_arready,
   input  logic [11:0]       s_araddr,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [63:0]       s_rdata,
   output logic [1:0]        s_rresp,
   input  logic [NUM_CH-1:0] cal_success,
   input  logic [NUM_CH-1:0] cal_fail,
   output logic [10:0]       memss_address,
   output logic              memss_read,
   output logic              memss_write,
   output logic [31:0]       memss_writedata,
   output logic [3:0]        memss_byteenable,
   input  logic              memss_waitrequest,
   input  logic [31:0]       memss_readdata,
   input  logic              memss_readdatavalid
);

   typedef enum logic [2:0] {
      IDLE, LRESP, WR_MEM, RD_MEM, RD_WAIT, BRESP, RRESP
   } state_e;

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [63:0] ERR_DATA = 64'hDEADBEEF_DEADBEEF;

   state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0] scratch_q, scratch_d;
   logic [63:0] rdata_q, rdata_d;
   logic [1:0] resp_q, resp_d;
   logic wr_q, wr_d;
   logic [10:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0] be_q, be_d;
   logic [SYNC_STAGES-1:0][2*NUM_CH-1:0] sync_q, sync_d;

   logic [63:0] dfh, status, cap, lrd;
   logic tmo;

   assign dfh = {4'h3, 8'h0, 4'h0, 7'h0, END_OF_LIST,
                 NEXT_DFH_OFFSET, FEAT_VER, 12'h009};

   // Synchroniser word: {fail, success}; last stage feeds STATUS.
   always_comb begin
      sync_d = sync_q;
      sync_d[0] = {cal_fail, cal_success};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   always_comb begin
      status = '0;
      status[NUM_CH-1:0] = sync_q[SYNC_STAGES-1][NUM_CH-1:0];
      status[16 +: NUM_CH] = sync_q[SYNC_STAGES-1][2*NUM_CH-1:NUM_CH];
      cap = '0;
      cap[NUM_CH-1:0] = '1;
      case (s_araddr[11:3])
         9'd0:    lrd = dfh;
         9'd1:    lrd = status;
         9'd2:    lrd = cap;
         9'd3:    lrd = scratch_q;
         default: lrd = '0;
      endcase
   end

   // >= so an accept on the final count still times out in RD_WAIT.
   assign tmo = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      scratch_d = scratch_q;
      rdata_d = rdata_q;
      resp_d = resp_q;
      wr_d = wr_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      be_d = be_q;
      s_awready = 1'b0;
      s_wready = 1'b0;
      s_arready = 1'b0;
      s_bvalid = 1'b0;
      s_rvalid = 1'b0;
      memss_read = 1'b0;
      memss_write = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s_awvalid && s_wvalid) begin
               s_awready = 1'b1;
               s_wready = 1'b1;
               wr_d = 1'b1;
               resp_d = OKAY;
               addr_d = s_awaddr[10:0];
               wdata_d = s_awaddr[2] ? s_wdata[63:32] : s_wdata[31:0];
               be_d = s_awaddr[2] ? s_wstrb[7:4] : s_wstrb[3:0];
               if (s_awaddr[11]) begin
                  state_d = WR_MEM;
                  cnt_d = '0;
               end else begin
                  state_d = LRESP;
                  if (s_awaddr[11:3] == 9'd3) begin
                     for (int b = 0; b < 8; b++)
                        if (s_wstrb[b]) scratch_d[8*b +: 8] = s_wdata[8*b +: 8];
                  end
               end
            end else if (s_arvalid) begin
               s_arready = 1'b1;
               wr_d = 1'b0;
               resp_d = OKAY;
               addr_d = s_araddr[10:0];
               if (s_araddr[11]) begin
                  state_d = RD_MEM;
                  cnt_d = '0;
               end else begin
                  state_d = LRESP;
                  rdata_d = lrd;
               end
            end
         end
         LRESP: begin
            s_bvalid = wr_q;
            s_rvalid = !wr_q;
            if (wr_q ? s_bready : s_rready) state_d = IDLE;
         end
         WR_MEM: begin
            memss_write = 1'b1;
            if (!memss_waitrequest) begin
               state_d = BRESP;
            end else if (tmo) begin
               state_d = BRESP;
               resp_d = SLVERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_MEM: begin
            memss_read = 1'b1;
            if (!memss_waitrequest) begin
               state_d = RD_WAIT;
               cnt_d = cnt_q + 1'b1;
            end else if (tmo) begin
               state_d = RRESP;
               resp_d = SLVERR;
               rdata_d = ERR_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_WAIT: begin
            if (memss_readdatavalid) begin
               state_d = RRESP;
               rdata_d = {2{memss_readdata}};
            end else if (tmo) begin
               state_d = RRESP;
               resp_d = SLVERR;
               rdata_d = ERR_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BRESP: begin
            s_bvalid = 1'b1;
            if (s_bready) state_d = IDLE;
         end
         RRESP: begin
            s_rvalid = 1'b1;
            if (s_rready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         scratch_q <= '0;
         rdata_q <= '0;
         resp_q <= '0;
         wr_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         be_q <= '0;
         sync_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         scratch_q <= scratch_d;
         rdata_q <= rdata_d;
         resp_q <= resp_d;
         wr_q <= wr_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         be_q <= be_d;
         sync_q <= sync_d;
      end
   end

   assign s_bresp = resp_q;
   assign s_rresp = resp_q;
   assign s_rdata = rdata_q;
   assign memss_address = addr_q;
   assign memss_writedata = wdata_q;
   assign memss_byteenable = be_q;

endmodule

// File: tb/tb_mem_ss_csr_dfh_bridge.sv
// Randomized bench for mem_ss_csr_dfh_bridge against a register/memory
// model; includes the AVMM slave responder and timeout scenarios.
module tb_mem_ss_csr_dfh_bridge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic s_awvalid, s_awready, s_wvalid, s_wready;
   logic [11:0] s_awaddr, s_araddr;
   logic [63:0] s_wdata, s_rdata;
   logic [7:0] s_wstrb;
   logic s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
   logic [1:0] s_bresp, s_rresp;
   logic [3:0] cal_success, cal_fail;
   logic [10:0] memss_address;
   logic memss_read, memss_write, memss_waitrequest, memss_readdatavalid;
   logic [31:0] memss_writedata, memss_readdata;
   logic [3:0] memss_byteenable;

   int n_chk = 0;
   int n_fail = 0;
   logic [63:0] scr_m;
   logic [31:0] mem_m [512];

   always #5 clk = ~clk;

   mem_ss_csr_dfh_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_bresp(s_bresp), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_araddr(s_araddr), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_rdata(s_rdata), .s_rresp(s_rresp),
      .cal_success(cal_success), .cal_fail(cal_fail),
      .memss_address(memss_address), .memss_read(memss_read),
      .memss_write(memss_write), .memss_writedata(memss_writedata),
      .memss_byteenable(memss_byteenable),
      .memss_waitrequest(memss_waitrequest),
      .memss_readdata(memss_readdata),
      .memss_readdatavalid(memss_readdatavalid)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] loc_rd(input logic [11:0] a);
      case (a[11:3])
         9'd0:    return 64'h3000_0000_1000_1009;
         9'd1:    return (64'(cal_fail) << 16) | 64'(cal_success);
         9'd2:    return 64'hF;
         9'd3:    return scr_m;
         default: return 64'h0;
      endcase
   endfunction

   // One AXI transaction; for the window, also plays the AVMM slave.
   task automatic txn(input bit wr, input logic [11:0] a,
                      input logic [63:0] d, input logic [7:0] st,
                      input int ws, input int lat, input bit drop);
      logic [63:0] ed;
      logic [1:0] er;
      logic [31:0] ew;
      logic [3:0] eb;
      int ln, n;
      ln = a[2] ? 1 : 0;
      ew = 32'(d >> (32 * ln));
      eb = 4'(st >> (4 * ln));
      er = (!wr && a[11] && drop) ? 2'b10 : 2'b00;
      if (a[11]) ed = drop ? 64'hDEADBEEF_DEADBEEF : {2{mem_m[a[10:2]]}};
      else ed = loc_rd(a);
      if (wr && !a[11] && a[11:3] == 9'd3) begin
         for (int b = 0; b < 8; b++)
            if (st[b]) scr_m[8*b +: 8] = d[8*b +: 8];
      end
      if (wr && a[11]) begin
         for (int b = 0; b < 4; b++)
            if (eb[b]) mem_m[a[10:2]][8*b +: 8] = ew[8*b +: 8];
      end
      memss_waitrequest = 1'b1;
      if (wr) begin
         s_awvalid = 1'b1; s_wvalid = 1'b1;
         s_awaddr = a; s_wdata = d; s_wstrb = st;
      end else begin
         s_arvalid = 1'b1; s_araddr = a;
      end
      #1;
      n = 0;
      while (!(wr ? (s_awready && s_wready) : s_arready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept", 64'(n < 20), 64'd1);
      @(negedge clk);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      if (a[11]) begin
         check("cmd", 64'(wr ? memss_write : memss_read), 64'd1);
         check("maddr", 64'(memss_address), 64'(a[10:0]));
         if (wr) begin
            check("wdata", 64'(memss_writedata), 64'(ew));
            check("be", 64'(memss_byteenable), 64'(eb));
         end
         repeat (ws) @(negedge clk);
         check("cmd_hold", 64'(wr ? memss_write : memss_read), 64'd1);
         memss_waitrequest = 1'b0;
         @(negedge clk);
         memss_waitrequest = 1'b1;
         check("cmd_drop", 64'(memss_write | memss_read), 64'd0);
         if (!wr && !drop) begin
            repeat (lat) @(negedge clk);
            memss_readdata = mem_m[a[10:2]];
            memss_readdatavalid = 1'b1;
            @(negedge clk);
            memss_readdatavalid = 1'b0;
            memss_readdata = $urandom;
         end
      end
      n = 0;
      while (!(wr ? s_bvalid : s_rvalid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("resp_seen", 64'(n < 400), 64'd1);
      if (!a[11]) check("local_lat", 64'(n), 64'd0);
      if (drop) check("tmo_early", 64'(n >= 240), 64'd1);
      check("resp", 64'(wr ? s_bresp : s_rresp), 64'(er));
      if (!wr) check("rdata", s_rdata, ed);
      @(negedge clk);
      check("resp_hold", 64'(wr ? s_bvalid : s_rvalid), 64'd1);
      s_bready = wr; s_rready = !wr;
      @(negedge clk);
      s_bready = 1'b0; s_rready = 1'b0;
      check("resp_clr", 64'(s_bvalid | s_rvalid), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] a;
      logic [63:0] dd;
      bit wr, drop;
      int kind;
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0;
      s_bready = 0; s_rready = 0;
      memss_waitrequest = 1; memss_readdata = 0; memss_readdatavalid = 0;
      cal_success = 4'b0101; cal_fail = 4'b0010;
      scr_m = '0;
      for (int i = 0; i < 512; i++) mem_m[i] = $urandom;
      repeat (3) @(negedge clk);
      check("rst_bvalid", 64'(s_bvalid), 64'd0);
      check("rst_rvalid", 64'(s_rvalid), 64'd0);
      check("rst_cmd", 64'(memss_read | memss_write), 64'd0);
      check("rst_rdata", s_rdata, 64'd0);
      check("rst_maddr", 64'(memss_address), 64'd0);
      check("rst_be", 64'(memss_byteenable), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      txn(0, 12'h000, 0, 0, 0, 0, 0);
      txn(0, 12'h008, 0, 0, 0, 0, 0);
      txn(0, 12'h010, 0, 0, 0, 0, 0);
      txn(1, 12'h018, 64'hA5A5_A5A5_1234_5678, 8'h0F, 0, 0, 0);
      txn(0, 12'h018, 0, 0, 0, 0, 0);
      mem_m[9'h018] = 32'h0001_0000;
      txn(0, 12'h860, 0, 0, 2, 3, 0);
      txn(1, 12'h864, 64'h0000_00AB_0000_0000, 8'hF0, 1, 0, 0);
      txn(0, 12'h870, 0, 0, 0, 0, 1);
      memss_readdatavalid = 1'b1;
      @(negedge clk);
      memss_readdatavalid = 1'b0;
      txn(0, 12'h018, 0, 0, 0, 0, 0);

      // aw+w+ar together: write first, read afterwards.
      dd = 64'h0123_4567_89AB_CDEF;
      s_awvalid = 1; s_wvalid = 1; s_awaddr = 12'h018;
      s_wdata = dd; s_wstrb = 8'hFF;
      s_arvalid = 1; s_araddr = 12'h018;
      #1;
      check("both_aw", 64'(s_awready && s_wready), 64'd1);
      check("both_ar", 64'(s_arready), 64'd0);
      @(negedge clk);
      s_awvalid = 0; s_wvalid = 0;
      scr_m = dd;
      check("both_b", 64'(s_bvalid), 64'd1);
      check("both_ar_blk", 64'(s_arready), 64'd0);
      s_bready = 1;
      @(negedge clk);
      s_bready = 0;
      check("both_ar2", 64'(s_arready), 64'd1);
      @(negedge clk);
      s_arvalid = 0;
      check("both_r", 64'(s_rvalid), 64'd1);
      check("both_rd", s_rdata, scr_m);
      s_rready = 1;
      @(negedge clk);
      s_rready = 0;

      for (int it = 0; it < 80; it++) begin
         if (it % 20 == 10) begin
            cal_success = 4'($urandom);
            cal_fail = 4'($urandom);
            repeat (4) @(negedge clk);
         end
         kind = $urandom_range(0, 2);
         wr = 1'($urandom);
         if (kind == 0) a = 12'($urandom_range(0, 4) * 8);
         else if (kind == 1) a = {1'b0, 11'($urandom)};
         else a = {1'b1, 11'($urandom)};
         drop = !wr && a[11] && ($urandom_range(0, 19) == 0);
         dd = {$urandom, $urandom};
         txn(wr, a, dd, 8'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), drop);
      end

      // Reset while a window read is stalled.
      s_arvalid = 1; s_araddr = 12'h900;
      memss_waitrequest = 1;
      @(negedge clk);
      s_arvalid = 0;
      check("mid_cmd", 64'(memss_read), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cmd", 64'(memss_read), 64'd0);
      check("mid_rst_rv", 64'(s_rvalid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      scr_m = '0;
      repeat (3) @(negedge clk);
      txn(0, 12'h018, 0, 0, 0, 0, 0);
      txn(0, 12'h008, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
